// File: rtl/rand_arbiter_if.sv
// rand_arbiter_if: bundle between rand_arbiter and its surroundings (the LFSR
// bank and the requesting pipeline stages).
//   reseed      - single-cycle reload request from the system
//   lfsr_rst    - synchronous reload strobe to the LFSR bank
//   lfsr_data   - current word from the LFSR bank
//   req / gnt   - level requests in, one-hot grant out
//   rand_out    - random word for the granted requester
//   rand_valid  - gnt/rand_out valid this cycle
//   ready       - arbiter running, grants possible
//   grant_count - total grants since rst (zero unless statistics are built in)
// Modport master is the arbiter side; slave is the environment side.
interface rand_arbiter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4
);
  logic             reseed;
  logic             lfsr_rst;
  logic [WIDTH-1:0] lfsr_data;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] rand_out;
  logic             rand_valid;
  logic             ready;
  logic [31:0]      grant_count;

  modport master (
    input  reseed, lfsr_data, req,
    output lfsr_rst, gnt, rand_out, rand_valid, ready, grant_count
  );

  modport slave (
    output reseed, lfsr_data, req,
    input  lfsr_rst, gnt, rand_out, rand_valid, ready, grant_count
  );
endinterface

// File: rtl/rand_arbiter.sv
// rand_arbiter: sequencing controller and round-robin arbiter for the shared
// LFSR random-word bank. Reloads the bank, waits WARMUP cycles, then hands one
// fresh word per cycle to at most one requester, scanning from the last winner.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - rand_arbiter_if.master (reseed, lfsr_rst, lfsr_data, req, gnt,
//         rand_out, rand_valid, ready, grant_count)
// Build option: define RAND_ARB_STATS_EN to get a 32-bit grant counter on
// grant_count; otherwise grant_count is tied to zero.
module rand_arbiter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WARMUP = 4
) (
  input logic            clk,
  input logic            rst,
  rand_arbiter_if.master bus
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {
    StReseed,
    StWarmup,
    StRun
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [IdxW-1:0]  last_q;
  logic             lfsr_rst_q;
  logic [NREQ-1:0]  gnt_q;
  logic [WIDTH-1:0] rand_q;
  logic             valid_q;
  logic             ready_q;

  logic             pick_valid;
  logic [IdxW-1:0]  pick_idx;
  logic [NREQ-1:0]  pick_onehot;
  int unsigned      cand;
  logic             grant_fire;

  // Round-robin pick: first set request at last+1, last+2, ... modulo NREQ.
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_q) + k) % NREQ;
      if (!pick_valid && bus.req[cand[IdxW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
    if (pick_valid) begin
      pick_onehot[pick_idx] = 1'b1;
    end
  end

  // Reseed beats any request on the same edge.
  assign grant_fire = (state_q == StRun) && !bus.reseed && pick_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReseed;
      cnt_q      <= '0;
      last_q     <= IdxW'(NREQ - 1);
      lfsr_rst_q <= 1'b1;
      gnt_q      <= '0;
      rand_q     <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else if (bus.reseed) begin
      // last_q is deliberately kept so fairness carries across reseeds.
      state_q    <= StReseed;
      lfsr_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StReseed: begin
          state_q    <= StWarmup;
          lfsr_rst_q <= 1'b0;
          cnt_q      <= CntW'(WARMUP - 1);
        end
        StWarmup: begin
          if (cnt_q == '0) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRun: begin
          if (grant_fire) begin
            gnt_q   <= pick_onehot;
            rand_q  <= bus.lfsr_data;
            valid_q <= 1'b1;
            last_q  <= pick_idx;
          end else begin
            gnt_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StReseed;
          lfsr_rst_q <= 1'b1;
          ready_q    <= 1'b0;
          gnt_q      <= '0;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lfsr_rst   = lfsr_rst_q;
  assign bus.gnt        = gnt_q;
  assign bus.rand_out   = rand_q;
  assign bus.rand_valid = valid_q;
  assign bus.ready      = ready_q;

`ifdef RAND_ARB_STATS_EN
  logic [31:0] count_q;

  // Only rst clears the counter; reseed leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (grant_fire) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.grant_count = count_q;
`else
  assign bus.grant_count = 32'd0;
`endif

endmodule

// File: tb/tb_rand_arbiter.sv
module tb_rand_arbiter;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned WARMUP = 4;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  rand_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  rand_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .WARMUP(WARMUP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // LFSR bank stand-in: synchronous reload on lfsr_rst, else advance.
  logic [15:0] lfsr_q = SEED;
  always @(posedge clk) begin
    if (bus.lfsr_rst) lfsr_q <= SEED;
    else              lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign bus.lfsr_data = lfsr_q;

  // Reference model: tracks edges since the last reload request and applies the
  // round-robin rule directly.
  int          m_since;
  int          m_last;
  logic [3:0]  exp_gnt;
  logic        exp_valid;
  logic [15:0] exp_rand;
  logic [31:0] m_count;
  logic        exp_ready;
  logic        exp_lfsr_rst;
  logic [31:0] exp_count;

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= int'(NREQ); k++) begin
      int c;
      c = (last + k) % int'(NREQ);
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_since   <= 0;
      m_last    <= NREQ - 1;
      exp_gnt   <= '0;
      exp_valid <= 1'b0;
      exp_rand  <= '0;
      m_count   <= '0;
    end else if (bus.reseed) begin
      m_since   <= 0;
      exp_gnt   <= '0;
      exp_valid <= 1'b0;
    end else begin
      m_since <= (m_since < 1000) ? m_since + 1 : m_since;
      if (m_since >= int'(WARMUP) + 1 && rr_pick(m_last, bus.req) >= 0) begin
        exp_gnt   <= 4'(1) << rr_pick(m_last, bus.req);
        exp_valid <= 1'b1;
        exp_rand  <= lfsr_q;
        m_last    <= rr_pick(m_last, bus.req);
        m_count   <= m_count + 32'd1;
      end else begin
        exp_gnt   <= '0;
        exp_valid <= 1'b0;
      end
    end
  end

  assign exp_ready    = (m_since >= int'(WARMUP) + 1);
  assign exp_lfsr_rst = (m_since == 0);
`ifdef RAND_ARB_STATS_EN
  assign exp_count = m_count;
`else
  assign exp_count = 32'd0;
`endif

  logic [15:0] ref_words[$];

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_timeout ready=%b required=1", tag, bus.ready);
    end
  endtask

  task automatic test_reset();
    bus.req    = 4'b1111;
    bus.reseed = 1'b0;
    rst        = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.lfsr_rst !== 1'b1) begin
        failures++; $display("FAIL reset_lfsr_rst got=%b required=1", bus.lfsr_rst);
      end
      checks++;
      if (bus.ready !== 1'b0) begin
        failures++; $display("FAIL reset_ready got=%b required=0", bus.ready);
      end
      checks++;
      if (bus.rand_valid !== 1'b0 || bus.gnt !== 4'b0000) begin
        failures++;
        $display("FAIL reset_grant valid=%b gnt=%b required 0/0000", bus.rand_valid, bus.gnt);
      end
      checks++;
      if (bus.rand_out !== 16'h0000 || bus.grant_count !== 32'd0) begin
        failures++;
        $display("FAIL reset_data rand_out=%h count=%0d required 0/0", bus.rand_out,
                 bus.grant_count);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= int'(WARMUP) + 1; e++) begin
      @(negedge clk);
      checks++;
      if (bus.lfsr_rst !== 1'b0) begin
        failures++; $display("FAIL boot_lfsr_rst edge=%0d got=%b required=0", e, bus.lfsr_rst);
      end
      checks++;
      if (bus.ready !== (e == int'(WARMUP) + 1)) begin
        failures++;
        $display("FAIL boot_ready edge=%0d got=%b required=%b", e, bus.ready,
                 e == int'(WARMUP) + 1);
      end
      checks++;
      if (bus.rand_valid !== 1'b0) begin
        failures++; $display("FAIL boot_no_valid edge=%0d got=%b required=0", e, bus.rand_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    int ord_a[6] = '{0, 1, 2, 3, 0, 1};
    int ord_b[3] = '{3, 1, 3};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rand_valid !== 1'b1 || bus.gnt !== 4'(1 << ord_a[i])) begin
        failures++;
        $display("FAIL rr_full_order i=%0d gnt=%b valid=%b required gnt=%b", i, bus.gnt,
                 bus.rand_valid, 4'(1 << ord_a[i]));
      end
      checks++;
      if (bus.rand_out !== exp_rand) begin
        failures++; $display("FAIL rr_full_word i=%0d got=%h required=%h", i, bus.rand_out, exp_rand);
      end
      ref_words.push_back(exp_rand);
    end
    bus.req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rand_valid !== 1'b1 || bus.gnt !== 4'(1 << ord_b[i])) begin
        failures++;
        $display("FAIL rr_partial_order i=%0d gnt=%b valid=%b required gnt=%b", i, bus.gnt,
                 bus.rand_valid, 4'(1 << ord_b[i]));
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] prev;
    prev = bus.rand_out;
    bus.req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0100 || bus.rand_valid !== 1'b1) begin
        failures++;
        $display("FAIL single_gnt i=%0d gnt=%b valid=%b required 0100/1", i, bus.gnt, bus.rand_valid);
      end
      checks++;
      if (bus.rand_out !== exp_rand || bus.rand_out === prev) begin
        failures++;
        $display("FAIL single_word i=%0d got=%h required=%h prev=%h", i, bus.rand_out, exp_rand, prev);
      end
      prev = bus.rand_out;
    end
  endtask

  task automatic test_reseed();
    int ord[4] = '{3, 0, 1, 2};
    bus.req    = 4'b1111;
    bus.reseed = 1'b1;
    @(negedge clk);
    bus.reseed = 1'b0;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.rand_valid !== 1'b0) begin
      failures++;
      $display("FAIL reseed_no_grant gnt=%b valid=%b required 0000/0", bus.gnt, bus.rand_valid);
    end
    checks++;
    if (bus.ready !== 1'b0 || bus.lfsr_rst !== 1'b1) begin
      failures++;
      $display("FAIL reseed_ctrl ready=%b lfsr_rst=%b required 0/1", bus.ready, bus.lfsr_rst);
    end
    for (int c = 1; c <= int'(WARMUP) + 1; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ready !== (c == int'(WARMUP) + 1) || bus.rand_valid !== 1'b0) begin
        failures++;
        $display("FAIL reseed_recover c=%0d ready=%b valid=%b required ready=%b valid=0", c,
                 bus.ready, bus.rand_valid, c == int'(WARMUP) + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'(1 << ord[i]) || bus.rand_valid !== 1'b1) begin
        failures++;
        $display("FAIL reseed_rr i=%0d gnt=%b required=%b", i, bus.gnt, 4'(1 << ord[i]));
      end
      checks++;
      if (bus.rand_out !== ref_words[i]) begin
        failures++;
        $display("FAIL reseed_replay i=%0d got=%h required=%h", i, bus.rand_out, ref_words[i]);
      end
    end
  endtask

  task automatic test_nested_reseed();
    bus.req    = 4'b0000;
    bus.reseed = 1'b1;
    @(negedge clk);
    bus.reseed = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b0 || bus.lfsr_rst !== 1'b0) begin
        failures++;
        $display("FAIL nested_warmup c=%0d ready=%b lfsr_rst=%b required 0/0", c, bus.ready,
                 bus.lfsr_rst);
      end
    end
    bus.reseed = 1'b1;
    @(negedge clk);
    bus.reseed = 1'b0;
    checks++;
    if (bus.lfsr_rst !== 1'b1 || bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL nested_back_to_reseed lfsr_rst=%b ready=%b required 1/0", bus.lfsr_rst,
               bus.ready);
    end
    for (int c = 1; c <= int'(WARMUP) + 1; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ready !== (c == int'(WARMUP) + 1)) begin
        failures++;
        $display("FAIL nested_ready c=%0d got=%b required=%b", c, bus.ready, c == int'(WARMUP) + 1);
      end
    end
  endtask

  task automatic test_stats();
    int grants;
    logic [31:0] want;
`ifdef RAND_ARB_STATS_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("stats");
    bus.req = 4'b1111;
    grants = 0;
    for (int n = 0; n < 30 && grants < 10; n++) begin
      @(negedge clk);
      if (bus.rand_valid === 1'b1) grants++;
    end
    bus.req = 4'b0000;
    checks++;
    if (grants != 10) begin
      failures++; $display("FAIL stats_grants got=%0d required=10", grants);
    end
    @(negedge clk);
    checks++;
    if (bus.grant_count !== want) begin
      failures++; $display("FAIL stats_count got=%0d required=%0d", bus.grant_count, want);
    end
    bus.reseed = 1'b1;
    @(negedge clk);
    bus.reseed = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant_count !== want) begin
      failures++; $display("FAIL stats_after_reseed got=%0d required=%0d", bus.grant_count, want);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.grant_count !== 32'd0) begin
      failures++; $display("FAIL stats_after_rst got=%0d required=0", bus.grant_count);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_ready("stats_rst");
  endtask

  task automatic test_async_reset();
    bus.req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.rand_valid !== 1'b1) begin
      failures++; $display("FAIL async_pre_valid got=%b required=1", bus.rand_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rand_valid !== 1'b0 || bus.gnt !== 4'b0000 || bus.rand_out !== 16'h0000) begin
      failures++;
      $display("FAIL async_clear valid=%b gnt=%b rand_out=%h required 0/0000/0000",
               bus.rand_valid, bus.gnt, bus.rand_out);
    end
    checks++;
    if (bus.ready !== 1'b0 || bus.lfsr_rst !== 1'b1) begin
      failures++;
      $display("FAIL async_ctrl ready=%b lfsr_rst=%b required 0/1", bus.ready, bus.lfsr_rst);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_ready("async");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.req    = 4'($urandom);
      bus.reseed = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      checks++;
      if (bus.gnt !== exp_gnt || bus.rand_valid !== exp_valid || bus.rand_out !== exp_rand) begin
        failures++;
        $display("FAIL random_grant i=%0d gnt=%b valid=%b word=%h required %b/%b/%h", i, bus.gnt,
                 bus.rand_valid, bus.rand_out, exp_gnt, exp_valid, exp_rand);
      end
      checks++;
      if (bus.ready !== exp_ready || bus.lfsr_rst !== exp_lfsr_rst ||
          bus.grant_count !== exp_count) begin
        failures++;
        $display("FAIL random_ctrl i=%0d ready=%b lfsr_rst=%b count=%0d required %b/%b/%0d", i,
                 bus.ready, bus.lfsr_rst, bus.grant_count, exp_ready, exp_lfsr_rst, exp_count);
      end
    end
    bus.reseed = 1'b0;
    bus.req    = 4'b0000;
  endtask

  initial begin
    bus.req    = 4'b1111;
    bus.reseed = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_reseed();
    test_nested_reseed();
    test_stats();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
